// File: rtl/round_robin_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The requester side drives notEN/Req; the arbiter drives the registered grant outputs.
interface round_robin_arbiter8_if;
  logic       notEN;
  logic [7:0] Req;
  logic [7:0] Grant;
  logic [2:0] GrantID;
  logic       Busy;
  logic       Done;

  modport master (
    output notEN,
    output Req,
    input  Grant,
    input  GrantID,
    input  Busy,
    input  Done
  );

  modport slave (
    input  notEN,
    input  Req,
    output Grant,
    output GrantID,
    output Busy,
    output Done
  );
endinterface

// File: rtl/round_robin_arbiter8.sv
// Eight-way round-robin arbiter with a bounded grant hold time.
// Every grant ends with a one-cycle RELEASE gap that carries the Done pulse.
module round_robin_arbiter8 #(
  parameter int unsigned HOLD_LIMIT = 8
) (
  input logic                      CLK,
  input logic                      notRST,
  round_robin_arbiter8_if.slave    bus
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned IDW  = 3;
  localparam int unsigned CW   = 8;

  // Hold-counter value on the last cycle of a limited grant; unused when HOLD_LIMIT is 0.
  localparam logic [CW-1:0] HOLD_LAST = (HOLD_LIMIT == 0) ? '0 : CW'(HOLD_LIMIT - 1);
  localparam logic [CW-1:0] HOLD_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   hold_cnt;
  logic [NREQ-1:0] grant_q;
  logic [IDW-1:0]  grant_id_q;
  logic            busy_q;
  logic            done_q;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  idx;
  logic            arb_go;
  logic            hold_exit;
  logic            grant_exit;

  // First requester at or after ptr, wrapping 7 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IDW'(k);
      if (!win_found && bus.Req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign arb_go     = !bus.notEN && win_found;
  assign hold_exit  = (HOLD_LIMIT != 0) && (hold_cnt == HOLD_LAST);
  assign grant_exit = !bus.Req[grant_id_q] || bus.notEN || hold_exit;

  always_ff @(posedge CLK or negedge notRST) begin
    if (!notRST) begin
      state      <= IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, RELEASE: begin
          if (arb_go) begin
            state      <= GRANT;
            grant_q    <= NREQ'(1) << win_id;
            grant_id_q <= win_id;
            busy_q     <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (grant_exit) begin
            state      <= RELEASE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            ptr        <= grant_id_q + IDW'(1);
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          grant_q    <= '0;
          grant_id_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Grant   = grant_q;
  assign bus.GrantID = grant_id_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;

endmodule

// File: tb/tb_round_robin_arbiter8.sv
// Randomized bench for round_robin_arbiter8: a limited (8) and an unlimited (0) instance
// share the same stimulus and are compared every cycle against a grant-level reference model.
module tb_round_robin_arbiter8;

  logic       CLK = 1'b0;
  logic       notRST;
  logic       notEN;
  logic [7:0] Req;

  always #5 CLK = ~CLK;

  round_robin_arbiter8_if bus_a ();
  round_robin_arbiter8_if bus_b ();

  assign bus_a.notEN = notEN;
  assign bus_a.Req   = Req;
  assign bus_b.notEN = notEN;
  assign bus_b.Req   = Req;

  round_robin_arbiter8 #(.HOLD_LIMIT(8)) dut_a (.CLK(CLK), .notRST(notRST), .bus(bus_a));
  round_robin_arbiter8 #(.HOLD_LIMIT(0)) dut_b (.CLK(CLK), .notRST(notRST), .bus(bus_b));

  int errors = 0;
  int checks = 0;

  // Reference: who holds the grant (-1 = nobody), how many cycles it has been visible,
  // where the next search starts, and whether this cycle is the post-grant gap.
  int m_cur  [2];
  int m_held [2];
  int m_ptr  [2];
  int m_done [2];
  int hl     [2];
  int done_seen_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cur[d]  = -1;
      m_held[d] = 0;
      m_ptr[d]  = 0;
      m_done[d] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      if (m_cur[d] >= 0) begin
        if (!Req[m_cur[d]] || notEN || (hl[d] != 0 && m_held[d] >= hl[d])) begin
          m_ptr[d]  = (m_cur[d] + 1) % 8;
          m_cur[d]  = -1;
          m_done[d] = 1;
        end else begin
          m_held[d] = m_held[d] + 1;
          m_done[d] = 0;
        end
      end else begin
        m_done[d] = 0;
        if (!notEN) begin
          for (int i = 0; i < 8; i++) begin
            int j;
            j = (m_ptr[d] + i) % 8;
            if (m_cur[d] < 0 && Req[j]) begin
              m_cur[d]  = j;
              m_held[d] = 1;
            end
          end
        end
      end
    end
  endfunction

  task automatic check_dut(input int d, input string name, input logic [7:0] g,
                           input logic [2:0] id, input logic b, input logic dn);
    logic [7:0] eg;
    logic [2:0] eid;
    eg  = (m_cur[d] >= 0) ? (8'd1 << m_cur[d]) : 8'd0;
    eid = (m_cur[d] >= 0) ? 3'(m_cur[d]) : 3'd0;
    check({name, ".Grant"},   32'(g),  32'(eg));
    check({name, ".GrantID"}, 32'(id), 32'(eid));
    check({name, ".Busy"},    32'(b),  32'(m_cur[d] >= 0));
    check({name, ".Done"},    32'(dn), 32'(m_done[d]));
  endtask

  task automatic check_all();
    check_dut(0, "lim8",  bus_a.Grant, bus_a.GrantID, bus_a.Busy, bus_a.Done);
    check_dut(1, "unlim", bus_b.Grant, bus_b.GrantID, bus_b.Busy, bus_b.Done);
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
    if (bus_b.Done) done_seen_b++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset pulse placed between clock edges; release also lands between edges.
  task automatic pulse_reset();
    #1;
    notRST = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    notRST = 1'b1;
  endtask

  initial begin
    hl[0] = 8;
    hl[1] = 0;
    done_seen_b = 0;
    notRST = 1'b0;
    notEN  = 1'b1;
    Req    = 8'h00;
    model_reset();
    #12;
    check_all();
    notRST = 1'b1;

    // Two low-index requesters: 0 first, then 2 after the hold limit.
    notEN = 1'b0;
    Req   = 8'b0000_0101;
    run(24);

    // Everyone requesting: full rotation on the limited instance.
    Req = 8'hFF;
    run(90);

    // Grant owner drops its request; search wraps to the low bits.
    Req = 8'h08;
    run(12);
    Req = 8'b0000_1001;
    run(6);
    Req = 8'h00;
    run(4);

    // Enable removed mid-grant, then all requests with enable held off.
    Req = 8'h20;
    run(3);
    notEN = 1'b1;
    Req   = 8'hFF;
    run(8);
    notEN = 1'b0;
    Req   = 8'h00;
    run(3);

    // Sole requester 6: unlimited instance never lets go, limited one re-grants after the gap.
    Req = 8'h40;
    run(2);
    done_seen_b = 0;
    run(300);
    check("unlim.hold_grant", 32'(bus_b.Grant), 32'h40);
    check("unlim.no_done",    32'(done_seen_b), 32'd0);
    pulse_reset();
    check("unlim.reset_grant", 32'(bus_b.Grant), 32'h00);
    Req = 8'hC0;
    run(3);
    check("unlim.after_reset", 32'(bus_b.Grant), 32'h40);

    // Random traffic with sticky requests and occasional enable drops / resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) Req = 8'($urandom);
      if ($urandom_range(15) == 0) Req = 8'd1 << $urandom_range(7);
      notEN = ($urandom_range(11) == 0);
      if ($urandom_range(499) == 0) pulse_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
